// File: rtl/frame_write_sequencer.sv
// Frame write sequencer: decodes header/data word pairs from the config
// stream and issues a single one-hot FrameStrobe per frame write.
module frame_write_sequencer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 8
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [FrameBitsPerRow-1:0]            cfg_data,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err,
  output logic [15:0]                           frame_count
);

  localparam int SW = NumColumns * MaxFramesPerCol;

  localparam logic [7:0] SYNC = 8'hFA;
  localparam logic [7:0] NCOL = 8'(NumColumns);
  localparam logic [7:0] NFRM = 8'(MaxFramesPerCol);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e                     state_q;
  logic [7:0]                 col_q;
  logic [7:0]                 frame_q;
  logic [FrameBitsPerRow-1:0] data_q;
  logic [SW-1:0]              strobe_q;
  logic                       err_q;
  logic [15:0]                cnt_q;

  logic [7:0]    hdr_sync;
  logic [7:0]    hdr_col;
  logic [7:0]    hdr_frame;
  logic          hdr_ok;
  logic [15:0]   idx_d;
  logic [SW-1:0] strobe_d;
  logic          ready_d;

  assign hdr_sync  = cfg_data[31:24];
  assign hdr_col   = cfg_data[23:16];
  assign hdr_frame = cfg_data[15:8];

  assign hdr_ok = (hdr_sync == SYNC)
                & (hdr_col < NCOL)
                & (hdr_frame < NFRM);

  // 16-bit index: no wrap for any legal col/frame pair.
  assign idx_d = 16'(col_q) * 16'(MaxFramesPerCol)
               + 16'(frame_q);

  assign strobe_d = SW'(1) << idx_d;

  // Ready is a pure function of state, never of cfg_valid.
  assign ready_d = (state_q == IDLE) | (state_q == DATA);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      col_q    <= '0;
      frame_q  <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      strobe_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            if (hdr_ok) begin
              col_q   <= hdr_col;
              frame_q <= hdr_frame;
              state_q <= DATA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (cfg_valid) begin
            data_q  <= cfg_data;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          strobe_q <= strobe_d;
          state_q  <= STROBE;
        end
        STROBE: begin
          state_q <= HOLD;
        end
        HOLD: begin
          if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cfg_ready   = ready_d;
  assign busy        = ~ready_d | (state_q == DATA);
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign err         = err_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Directed bench for frame_write_sequencer: reset, single write, bad
// headers, stalled stream, back-to-back writes and reset mid-strobe.
module tb_frame_write_sequencer;

  localparam int SW = 160;

  logic          CLK;
  logic          RST;
  logic [31:0]   cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [31:0]   FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          busy;
  logic          err;
  logic [15:0]   frame_count;

  int vecs;
  int errs;
  int strobe_cycles;
  int multi_hot;
  int cyc;

  frame_write_sequencer #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(20),
    .NumColumns(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .err(err),
    .frame_count(frame_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (|FrameStrobe) begin
      strobe_cycles <= strobe_cycles + 1;
      if ($countones(FrameStrobe) != 1)
        multi_hot <= multi_hot + 1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents a word and returns at #1 after its handshake edge.
  task automatic send(input logic [31:0] w);
    int t;
    cfg_data  = w;
    cfg_valid = 1'b1;
    t = 0;
    while (!cfg_ready && t < 50) begin
      step();
      t++;
    end
    vecs++;
    if (!cfg_ready) begin
      errs++;
      $display("FAIL send_timeout word=%h ready=%b want 1",
               w, cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cfg_valid = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 32'hFA020500;
    step();
    step();
    vecs++;
    if (FrameStrobe !== '0 || FrameData !== 32'd0 ||
        err !== 1'b0 || frame_count !== 16'd0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_outs data=%h err=%b cnt=%0d busy=%b want 0",
               FrameData, err, frame_count, busy);
    end
    RST       = 1'b0;
    cfg_valid = 1'b0;
    step();
    vecs++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release ready=%b busy=%b want 1/0",
               cfg_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [SW-1:0] exp;
    int s0;
    exp = '0;
    exp[45] = 1'b1;
    s0 = strobe_cycles;
    send(32'hFA020500);
    vecs++;
    if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
      errs++;
      $display("FAIL single_data_state busy=%b ready=%b want 1/1",
               busy, cfg_ready);
    end
    send(32'hDEADBEEF);
    vecs++;
    if (FrameData !== 32'hDEADBEEF || FrameStrobe !== '0 ||
        cfg_ready !== 1'b0) begin
      errs++;
      $display("FAIL single_k1 data=%h ready=%b want deadbeef/0",
               FrameData, cfg_ready);
    end
    step();
    vecs++;
    if (FrameStrobe !== exp || FrameData !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL single_k2 strobe=%h want %h", FrameStrobe, exp);
    end
    step();
    vecs++;
    if (FrameStrobe !== '0 || FrameData !== 32'hDEADBEEF ||
        frame_count !== 16'd0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL single_k3 cnt=%0d data=%h want 0/deadbeef",
               frame_count, FrameData);
    end
    step();
    vecs++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 ||
        frame_count !== 16'd1 || strobe_cycles != s0 + 1) begin
      errs++;
      $display("FAIL single_k4 ready=%b cnt=%0d strobes=%0d want 1/1/1",
               cfg_ready, frame_count, strobe_cycles - s0);
    end
  endtask

  task automatic test_bad_headers();
    logic [31:0] bad [3];
    logic [SW-1:0] exp;
    int s0;
    bad[0] = 32'h12020500;
    bad[1] = 32'hFA080000;
    bad[2] = 32'hFA001400;
    s0 = strobe_cycles;
    for (int i = 0; i < 3; i++) begin
      send(bad[i]);
      vecs++;
      if (err !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
        errs++;
        $display("FAIL bad_hdr%0d err=%b ready=%b busy=%b want 1/1/0",
                 i, err, cfg_ready, busy);
      end
    end
    vecs++;
    if (strobe_cycles != s0) begin
      errs++;
      $display("FAIL bad_no_strobe strobes=%0d want 0",
               strobe_cycles - s0);
    end
    exp = '0;
    exp[140] = 1'b1;
    send(32'hFA070000);
    send(32'h13572468);
    step();
    vecs++;
    if (FrameStrobe !== exp || err !== 1'b1) begin
      errs++;
      $display("FAIL bad_then_legal strobe=%h err=%b want %h/1",
               FrameStrobe, err, exp);
    end
    step();
    step();
  endtask

  task automatic test_stall();
    logic [SW-1:0] exp;
    int s0;
    int gap_bad;
    exp = '0;
    exp[79] = 1'b1;
    s0 = strobe_cycles;
    gap_bad = 0;
    send(32'hFA031300);
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b1 || FrameStrobe !== '0) gap_bad++;
      step();
    end
    vecs++;
    if (gap_bad != 0) begin
      errs++;
      $display("FAIL stall_gap bad_cycles=%0d want 0", gap_bad);
    end
    send(32'h00000001);
    step();
    vecs++;
    if (FrameStrobe !== exp || FrameData !== 32'h00000001) begin
      errs++;
      $display("FAIL stall_strobe strobe=%h want %h", FrameStrobe, exp);
    end
    step();
    step();
    vecs++;
    if (strobe_cycles != s0 + 1) begin
      errs++;
      $display("FAIL stall_count strobes=%0d want 1", strobe_cycles - s0);
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] exp;
    logic [31:0]   w;
    int col;
    int frm;
    int last;
    int bad_idx;
    int bad_gap;
    int bad_rdy;
    do_reset();
    bad_idx = 0;
    bad_gap = 0;
    bad_rdy = 0;
    last = -1;
    cfg_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      col = i % 8;
      frm = ((i / 8) % 2 == 1) ? 19 : 0;
      w = 32'hFA000000 | (col << 16) | (frm << 8);
      cfg_data = w;
      if (cfg_ready !== 1'b1) bad_rdy++;
      step();
      cfg_data = 32'hA5000000 | i;
      if (cfg_ready !== 1'b1) bad_rdy++;
      step();
      step();
      exp = '0;
      exp[col * 20 + frm] = 1'b1;
      if (FrameStrobe !== exp) bad_idx++;
      if (last >= 0 && cyc - last != 5) bad_gap++;
      last = cyc;
      step();
      step();
    end
    cfg_valid = 1'b0;
    vecs++;
    if (bad_idx != 0 || bad_rdy != 0) begin
      errs++;
      $display("FAIL b2b_index bad_idx=%0d bad_rdy=%0d want 0/0",
               bad_idx, bad_rdy);
    end
    vecs++;
    if (bad_gap != 0) begin
      errs++;
      $display("FAIL b2b_spacing bad_gaps=%0d want 0", bad_gap);
    end
    vecs++;
    if (frame_count !== 16'd40) begin
      errs++;
      $display("FAIL b2b_count cnt=%0d want 40", frame_count);
    end
    vecs++;
    if (multi_hot != 0) begin
      errs++;
      $display("FAIL onehot multi_hot_cycles=%0d want 0", multi_hot);
    end
  endtask

  task automatic test_reset_mid_strobe();
    send(32'hFA041300);
    send(32'hCAFEF00D);
    step();
    vecs++;
    if (FrameStrobe === '0) begin
      errs++;
      $display("FAIL mid_pre strobe=%h want nonzero", FrameStrobe);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    vecs++;
    if (FrameStrobe !== '0 || frame_count !== 16'd0 ||
        FrameData !== 32'd0 || cfg_ready !== 1'b1 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset strobe=%h cnt=%0d data=%h busy=%b want 0",
               FrameStrobe, frame_count, FrameData, busy);
    end
    step();
    vecs++;
    if (FrameStrobe !== '0 || frame_count !== 16'd0) begin
      errs++;
      $display("FAIL mid_after strobe=%h cnt=%0d want 0/0",
               FrameStrobe, frame_count);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    strobe_cycles = 0;
    multi_hot = 0;
    cyc = 0;
    RST = 1'b1;
    cfg_valid = 1'b0;
    cfg_data = 32'd0;
    #2;
    test_reset();
    test_single();
    test_bad_headers();
    test_stall();
    test_back_to_back();
    test_reset_mid_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
